// File: rtl/crtc_pkg.sv
// Shared types and helpers for the CRTC character/scan-line timing slice.
package crtc_pkg;

  localparam int unsigned CRTC_MA_WIDTH = 14;

  typedef enum logic {
    ROWS,
    ADJUST
  } vstate_t;

  // A programmed width of 0 stands for the longest pulse when zero_is_16 is set.
  function automatic logic [4:0] sync_width(input logic [3:0] w, input bit zero_is_16);
    return (w == 4'd0 && zero_is_16) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/crtc_if.sv
// Register-file view and video outputs of the CRTC timing block.
interface crtc_if #(
  parameter int unsigned MA_WIDTH = crtc_pkg::CRTC_MA_WIDTH
) ();

  logic [7:0]          h_total;
  logic [7:0]          h_displayed;
  logic [7:0]          h_sync_pos;
  logic [3:0]          h_sync_width;
  logic [3:0]          v_sync_width;
  logic [6:0]          v_total;
  logic [4:0]          v_line_adjust;
  logic [6:0]          v_displayed;
  logic [6:0]          v_sync_pos;
  logic [4:0]          char_height;
  logic [MA_WIDTH-1:0] start_addr;

  logic                h_sync;
  logic                v_sync;
  logic                display_en;
  logic [MA_WIDTH-1:0] ma;
  logic [4:0]          ra;
  logic                frame_start;

  modport master (
    output h_total, h_displayed, h_sync_pos, h_sync_width, v_sync_width,
           v_total, v_line_adjust, v_displayed, v_sync_pos, char_height, start_addr,
    input  h_sync, v_sync, display_en, ma, ra, frame_start
  );

  modport slave (
    input  h_total, h_displayed, h_sync_pos, h_sync_width, v_sync_width,
           v_total, v_line_adjust, v_displayed, v_sync_pos, char_height, start_addr,
    output h_sync, v_sync, display_en, ma, ra, frame_start
  );

endinterface

// File: rtl/crtc_sync_pulse.sv
// Fixed-width sync pulse: starts on a strobe, lasts `width` advances, ignores retriggers.
module crtc_sync_pulse (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  input  logic       start,
  input  logic [4:0] width,
  output logic       pulse
);

  logic [4:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (adv) begin
      if (pulse) begin
        // >= so a width reduced mid-pulse still terminates
        if (cnt + 5'd1 >= width) pulse <= 1'b0;
        cnt <= cnt + 5'd1;
      end else if (start && width != '0) begin
        pulse <= 1'b1;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/crtc_timing.sv
// CRTC character/scan-line sequencer: line/row/frame counters, syncs, MA/RA generation.
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int unsigned MA_WIDTH        = CRTC_MA_WIDTH,
  parameter bit          SYNC_ZERO_IS_16 = 1'b1
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  char_en,
  crtc_if.slave bus
);

  vstate_t             state, state_nx;
  logic [7:0]          h_cnt;
  logic [6:0]          row, row_nx;
  logic [4:0]          ra_cnt, ra_nx;
  logic [4:0]          adj_cnt, adj_nx;
  logic [MA_WIDTH-1:0] ma_row, ma_row_nx;
  logic                line_end, frame_end;
  logic                h_disp, v_disp;

  always_comb begin
    line_end  = (h_cnt >= bus.h_total);
    h_disp    = (h_cnt < bus.h_displayed);
    v_disp    = (state == ROWS) && (row < bus.v_displayed);
    state_nx  = state;
    row_nx    = row;
    ra_nx     = ra_cnt;
    adj_nx    = adj_cnt;
    ma_row_nx = ma_row;
    frame_end = 1'b0;
    if (line_end) begin
      if (state == ROWS) begin
        if (ra_cnt >= bus.char_height) begin
          ra_nx     = '0;
          ma_row_nx = ma_row + MA_WIDTH'(bus.h_displayed);
          if (row >= bus.v_total) begin
            if (bus.v_line_adjust != '0) begin
              state_nx = ADJUST;
              adj_nx   = '0;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            row_nx = row + 7'd1;
          end
        end else begin
          ra_nx = ra_cnt + 5'd1;
        end
      end else begin
        adj_nx = adj_cnt + 5'd1;
        ra_nx  = ra_cnt + 5'd1;
        if (adj_cnt == bus.v_line_adjust - 5'd1) frame_end = 1'b1;
      end
      // Frame end overrides the row-end address increment
      if (frame_end) begin
        state_nx  = ROWS;
        row_nx    = '0;
        ra_nx     = '0;
        adj_nx    = '0;
        ma_row_nx = bus.start_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ROWS;
      h_cnt           <= '0;
      row             <= '0;
      ra_cnt          <= '0;
      adj_cnt         <= '0;
      ma_row          <= '0;
      bus.frame_start <= 1'b0;
      bus.display_en  <= 1'b0;
      bus.ma          <= '0;
      bus.ra          <= '0;
    end else begin
      bus.frame_start <= 1'b0;
      if (char_en) begin
        state           <= state_nx;
        h_cnt           <= line_end ? '0 : h_cnt + 8'd1;
        row             <= row_nx;
        ra_cnt          <= ra_nx;
        adj_cnt         <= adj_nx;
        ma_row          <= ma_row_nx;
        bus.frame_start <= frame_end;
        bus.display_en  <= h_disp && v_disp;
        bus.ma          <= ma_row + MA_WIDTH'(h_cnt);
        bus.ra          <= ra_cnt;
      end
    end
  end

  crtc_sync_pulse u_hsync (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (char_en),
    .start   (h_cnt == bus.h_sync_pos),
    .width   (sync_width(bus.h_sync_width, SYNC_ZERO_IS_16)),
    .pulse   (bus.h_sync)
  );

  // VSYNC starts on the line end that leads into the matching line
  crtc_sync_pulse u_vsync (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (char_en && line_end),
    .start   ((state_nx == ROWS) && (row_nx == bus.v_sync_pos) && (ra_nx == '0)),
    .width   (sync_width(bus.v_sync_width, SYNC_ZERO_IS_16)),
    .pulse   (bus.v_sync)
  );

endmodule

// File: tb/tb_crtc_timing.sv
// Scoreboard bench for crtc_timing against a frame-position arithmetic model.
module tb_crtc_timing;

  localparam int MAW = 14;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic char_en = 1'b0;

  crtc_if #(.MA_WIDTH(MAW)) bus ();

  crtc_timing #(.MA_WIDTH(MAW), .SYNC_ZERO_IS_16(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .char_en (char_en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            hs;
    logic            vs;
    logic            de;
    logic            fs;
    logic [MAW-1:0]  ma;
    logic [4:0]      ra;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  exp_t zero_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_edges  = 0;
  bit   mon_on   = 1'b0;
  logic mon_ce;

  int c_ht, c_hd, c_hsp, c_hsw, c_vsw, c_vt, c_adj, c_vd, c_vsp, c_ch, c_sa;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".h_sync"},      int'(bus.h_sync),      int'(e.hs));
    check({tag, ".v_sync"},      int'(bus.v_sync),      int'(e.vs));
    check({tag, ".display_en"},  int'(bus.display_en),  int'(e.de));
    check({tag, ".frame_start"}, int'(bus.frame_start), int'(e.fs));
    check({tag, ".ma"},          int'(bus.ma),          int'(e.ma));
    check({tag, ".ra"},          int'(bus.ra),          int'(e.ra));
  endtask

  function automatic bit is_vs_line(input int fl);
    int chh = c_ch + 1;
    int rl  = (c_vt + 1) * chh;
    return (fl < rl) && (fl % chh == 0) && (fl / chh == c_vsp);
  endfunction

  // Outputs after the n-th char_en since reset, from the frame position alone.
  function automatic exp_t model(input int n);
    exp_t e;
    int L    = c_ht + 1;
    int chh  = c_ch + 1;
    int rl   = (c_vt + 1) * chh;
    int fln  = rl + c_adj;
    int p    = n - 1;
    int c    = p % L;
    int al   = p / L;
    int fl   = al % fln;
    int fr   = al / fln;
    bit inr  = fl < rl;
    int row  = inr ? fl / chh : c_vt;
    int ra   = inr ? fl % chh : (fl - rl) % 32;
    int mrow = (fr == 0 ? 0 : c_sa) + (inr ? row : c_vt + 1) * c_hd;
    int w;
    int lm;
    e.ma = MAW'(mrow + c);
    e.ra = 5'(ra);
    e.de = inr && (row < c_vd) && (c < c_hd);
    e.fs = (n % (fln * L)) == 0;
    e.hs = 1'b0;
    w = (c_hsw == 0) ? 16 : c_hsw;
    for (int j = 0; j < w; j++)
      if (p - j >= 0 && (p - j) % L == c_hsp) e.hs = 1'b1;
    e.vs = 1'b0;
    w  = (c_vsw == 0) ? 16 : c_vsw;
    lm = n / L;
    for (int j = 0; j < w; j++)
      if (lm - j >= 1 && is_vs_line((lm - j) % fln)) e.vs = 1'b1;
    return e;
  endfunction

  task automatic set_cfg(input int ht, input int hd, input int hsp, input int hsw,
                         input int vsw, input int vt, input int adj, input int vd,
                         input int vsp, input int ch, input int sa);
    c_ht = ht; c_hd = hd; c_hsp = hsp; c_hsw = hsw; c_vsw = vsw; c_vt = vt;
    c_adj = adj; c_vd = vd; c_vsp = vsp; c_ch = ch; c_sa = sa;
    bus.h_total       = 8'(ht);
    bus.h_displayed   = 8'(hd);
    bus.h_sync_pos    = 8'(hsp);
    bus.h_sync_width  = 4'(hsw);
    bus.v_sync_width  = 4'(vsw);
    bus.v_total       = 7'(vt);
    bus.v_line_adjust = 5'(adj);
    bus.v_displayed   = 7'(vd);
    bus.v_sync_pos    = 7'(vsp);
    bus.char_height   = 5'(ch);
    bus.start_addr    = MAW'(sa);
  endtask

  task automatic set_default_cfg();
    set_cfg(63, 40, 48, 5, 1, 32, 0, 25, 28, 7, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    char_en = 1'b0;
    check({tag, ".sb_drained"}, q.size(), 0);
    #2 reset_n = 1'b0;
    #1 compare_all({tag, ".async_reset"}, zero_e);
    q.delete();
    n_edges  = 0;
    last_exp = zero_e;
    mon_on   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_chars(input int count, input int idle_pct);
    int done = 0;
    while (done < count) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < idle_pct) begin
        char_en = 1'b0;
      end else begin
        char_en = 1'b1;
        n_edges++;
        q.push_back(model(n_edges));
        done++;
      end
    end
    @(negedge clk);
    char_en = 1'b0;
  endtask

  // Monitor: a char_en edge pops the next expectation; idle clocks must hold it.
  always @(posedge clk) begin
    mon_ce = char_en;
    #1;
    if (mon_on && reset_n) begin
      if (mon_ce) begin
        check("sb_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          last_exp = q.pop_front();
          compare_all("edge", last_exp);
        end
      end else begin
        exp_t idle_e;
        idle_e    = last_exp;
        idle_e.fs = 1'b0;
        compare_all("idle", idle_e);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_edges=%0d", n_edges);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    zero_e.hs = 1'b0; zero_e.vs = 1'b0; zero_e.de = 1'b0;
    zero_e.fs = 1'b0; zero_e.ma = '0;   zero_e.ra = '0;
    last_exp  = zero_e;

    // Default register set, two full frames with sparse char_en gaps
    set_default_cfg();
    do_reset("t1");
    run_chars(2 * 16896 + 100, 3);

    // Start address near the top of memory, 3 adjust lines, short frame
    set_cfg(63, 40, 48, 5, 1, 4, 3, 3, 3, 7, 'h3FF0);
    do_reset("t2");
    run_chars(2 * 43 * 64 + 200, 10);

    // Zero sync widths: 16-char HSYNC across line end, 16-line VSYNC across frame end
    set_cfg(63, 40, 56, 0, 0, 6, 0, 5, 5, 3, 'h0100);
    do_reset("t3");
    run_chars(28 * 64, 10);
    repeat (10) @(negedge clk);
    run_chars(28 * 64 + 300, 10);

    // h_total lowered below the current h_cnt ends the line on the next char_en
    set_default_cfg();
    do_reset("t4");
    run_chars(40, 0);
    @(negedge clk);
    bus.h_total = 8'd20;
    char_en     = 1'b1;
    n_edges++;
    q.push_back(model(n_edges));
    e    = zero_e;
    e.de = 1'b1;
    e.ra = 5'd1;
    e.ma = '0;
    @(negedge clk);
    q.push_back(e);
    e.ma = MAW'(1);
    @(negedge clk);
    q.push_back(e);
    @(negedge clk);
    char_en = 1'b0;

    // Mid-row asynchronous reset, then restart
    set_default_cfg();
    do_reset("t5");
    run_chars(300, 10);
    repeat (10) @(negedge clk);
    do_reset("t5_mid");
    run_chars(100, 0);

    set_default_cfg();
    do_reset("final");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
